// File: rtl/pipe_ctrl_if.sv
// Control bundle between the RV32I pipeline datapath and the stall/flush sequencer.
// The master side is the datapath and the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             ex_mem_re;
  logic [4:0]       ex_rd_addr;
  logic             ex_jump_en;
  logic [31:0]      ex_jump_addr;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;

  logic             stall_pc;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             stall_ex_mem;
  logic             stall_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             pc_load;
  logic [31:0]      pc_load_addr;
  logic             halted_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_mem_re, ex_rd_addr, ex_jump_en, ex_jump_addr,
           mem_req, mem_ready, halt_req,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, pc_load, pc_load_addr, halted_o, bus_err_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_mem_re, ex_rd_addr, ex_jump_en, ex_jump_addr,
           mem_req, mem_ready, halt_req,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, pc_load, pc_load_addr, halted_o, bus_err_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: memory freeze with timeout,
// EX redirects, load-use bubbles, debug drain/halt and saturating perf counters.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave ctl
);
  localparam int unsigned FC_W = $clog2(MEM_TIMEOUT);
  localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  freeze_cnt_q;
  logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             bus_err_q, halted_q;

  logic             mem_wait, timeout_hit, freeze, redirect, hazard;
  logic             stall_pc_c, stall_if_id_c, stall_id_ex_c, stall_ex_mem_c, stall_mem_wb_c;
  logic             flush_if_id_c, flush_id_ex_c, pc_load_c;
  logic [31:0]      pc_load_addr_c;

  // Hazard and freeze qualifiers shared by the FSM and the counters
  always_comb begin
    mem_wait    = ctl.mem_req & ~ctl.mem_ready;
    timeout_hit = (freeze_cnt_q == FC_W'(MEM_TIMEOUT - 1));
    freeze      = mem_wait & ~timeout_hit;
    redirect    = ctl.ex_jump_en & ~freeze;
    hazard      = ctl.ex_mem_re && (ctl.ex_rd_addr != 5'd0) &&
                  ((ctl.ex_rd_addr == ctl.id_rs1_addr) || (ctl.ex_rd_addr == ctl.id_rs2_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    stall_pc_c     = 1'b0;
    stall_if_id_c  = 1'b0;
    stall_id_ex_c  = 1'b0;
    stall_ex_mem_c = 1'b0;
    stall_mem_wb_c = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    pc_load_c      = 1'b0;
    pc_load_addr_c = 32'd0;

    case (state_q)
      RUN: begin
        if (ctl.halt_req && !freeze) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!ctl.halt_req) begin
          state_d = RUN;
        end else if (!freeze) begin
          if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) state_d = HALTED;
          else drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
      HALTED: begin
        if (!ctl.halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (!rst_n) begin
      flush_if_id_c = 1'b1;
      flush_id_ex_c = 1'b1;
    end else if (freeze) begin
      stall_pc_c     = 1'b1;
      stall_if_id_c  = 1'b1;
      stall_id_ex_c  = 1'b1;
      stall_ex_mem_c = 1'b1;
      stall_mem_wb_c = 1'b1;
    end else if (redirect) begin
      pc_load_c      = 1'b1;
      pc_load_addr_c = ctl.ex_jump_addr;
      flush_if_id_c  = 1'b1;
      flush_id_ex_c  = 1'b1;
    end else begin
      case (state_q)
        RUN, DRAIN: begin
          // A load consumer in ID must be held even while draining, or it leaves with stale data
          if (hazard) begin
            stall_pc_c    = 1'b1;
            stall_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end else if (state_q == DRAIN) begin
            stall_pc_c    = 1'b1;
            flush_if_id_c = 1'b1;
          end
        end
        HALTED: begin
          stall_pc_c    = 1'b1;
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Freeze timer, timeout pulse, halt flag and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freeze_cnt_q <= '0;
      bus_err_q    <= 1'b0;
      halted_q     <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      freeze_cnt_q <= freeze ? freeze_cnt_q + FC_W'(1) : '0;
      bus_err_q    <= mem_wait & timeout_hit;
      halted_q     <= (state_d == HALTED);
      if (stall_pc_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign ctl.stall_pc     = stall_pc_c;
  assign ctl.stall_if_id  = stall_if_id_c;
  assign ctl.stall_id_ex  = stall_id_ex_c;
  assign ctl.stall_ex_mem = stall_ex_mem_c;
  assign ctl.stall_mem_wb = stall_mem_wb_c;
  assign ctl.flush_if_id  = flush_if_id_c;
  assign ctl.flush_id_ex  = flush_id_ex_c;
  assign ctl.pc_load      = pc_load_c;
  assign ctl.pc_load_addr = pc_load_addr_c;
  assign ctl.halted_o     = halted_q;
  assign ctl.bus_err_o    = bus_err_q;
  assign ctl.stall_cnt_o  = stall_cnt_q;
  assign ctl.flush_cnt_o  = flush_cnt_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards that ID-stage forwarding cannot cover, and squashes wrong-path instructions on EX-resolved jumps and branches. It freezes the whole pipeline while the data-memory access in MEM is outstanding, and drains the pipeline for a debug halt. It drives hold and flush enables to the PC register and to every pipeline register. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum freeze cycles waiting for dmem_ready before bus_err_o fires (>=2)
DRAIN_CYCLES, 4, non-frozen bubble cycles needed to empty ID..WB before halted_o
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_rs1_addr  in  5  rs1 index requested by ID
id_rs2_addr  in  5  rs2 index requested by ID
ex_mem_re  in  1  instruction in EX is a load
ex_rd_addr  in  5  destination register of EX instruction
ex_jump_en  in  1  EX resolved a taken jump/branch
ex_jump_addr  in  32  target of EX jump
mem_req  in  1  MEM stage has an active data access
mem_ready  in  1  data memory completes access this cycle
halt_req  in  1  debug halt request (level)
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
stall_mem_wb  out  1  hold MEM/WB
flush_if_id  out  1  load NOP into IF/ID
flush_id_ex  out  1  load NOP into ID/EX
pc_load  out  1  load PC with pc_load_addr
pc_load_addr  out  32  redirect target
halted_o  out  1  pipeline drained and halted
bus_err_o  out  1  one-cycle pulse on memory timeout
stall_cnt_o  out  CNT_W  cycles with stall_pc=1
flush_cnt_o  out  CNT_W  accepted redirects

Behaviour:
- Reset (rst_n=0 at a clk edge): state=RUN, freeze_cnt=0, drain_cnt=0, both counters=0, bus_err_o=0, halted_o=0.
- While rst_n=0, all stall_* =0, flush_if_id=flush_id_ex=1, pc_load=0, pc_load_addr=0.
- FSM states: RUN, DRAIN, HALTED (registered). Stall, flush and pc_load are combinational from state plus inputs, with the priority below.
- Priority 1, freeze: freeze = mem_req & ~mem_ready & ~timeout_hit, where timeout_hit = (freeze_cnt == MEM_TIMEOUT-1).
  - While freeze=1, all five stall_* =1, no flush, pc_load=0. ex_jump_en is ignored; the jump stays in EX and is re-presented after the freeze.
  - freeze_cnt increments each frozen cycle and clears on any cycle with freeze=0.
  - If mem_req & ~mem_ready & timeout_hit: no freeze that cycle, bus_err_o=1 for exactly one cycle (registered output, asserted the cycle after), freeze_cnt clears, and the access is treated as complete.
- Priority 2, redirect: when ex_jump_en=1 and not frozen, in any state: pc_load=1, pc_load_addr=ex_jump_addr, flush_if_id=1, flush_id_ex=1, no stalls.
  - A redirect overrides a simultaneous load-use hazard.
  - flush_cnt_o increments.
- Priority 3, load-use hazard: hazard = ex_mem_re & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1 (bubble). EX/MEM/WB advance.
  - The hazard clears naturally the next cycle, so the stall is exactly 1 cycle per load.
- RUN -> DRAIN when halt_req=1 and not frozen. drain_cnt clears.
- DRAIN:
  - stall_pc=1 and flush_if_id=1 every non-frozen cycle, feeding bubbles. Redirects still load the PC so the resume PC is correct.
  - drain_cnt increments only on non-frozen cycles.
  - At drain_cnt == DRAIN_CYCLES-1 go to HALTED.
  - If halt_req drops during DRAIN, return to RUN immediately.
- HALTED: halted_o=1, stall_pc=1, flush_if_id=1, flush_id_ex=1. When halt_req=0, go to RUN next cycle and drop halted_o.
- Counters saturate at all-ones and never wrap.
- stall_cnt_o counts every cycle with stall_pc=1, including freeze, drain and halted cycles.

Test Plan:
- lw x5 in EX, ID reads rs2=x5 -> exactly one cycle of stall_pc=stall_if_id=flush_id_ex=1, then no stall; stall_cnt_o=1.
- ex_mem_re=1, ex_rd_addr=0, id_rs1_addr=0 -> no stall.
- ex_jump_en=1, ex_jump_addr=0x0000_0100, same cycle as a load-use hazard -> pc_load=1, addr=0x100, both flushes, no stall_pc; flush_cnt_o=1.
- mem_req=1, mem_ready low for 3 cycles then high -> all five stalls high for 3 cycles, released on the ready cycle, no bus_err_o.
- mem_req=1, mem_ready never rises, MEM_TIMEOUT=16 -> 15 frozen cycles, release on the 16th, bus_err_o pulses once.
- halt_req=1 with one mem freeze of 2 cycles mid-drain -> halted_o rises after 4 non-frozen drain cycles.
  - Drop halt_req -> RUN next cycle.
  - Reset asserted during DRAIN -> RUN, halted_o=0, counters 0.
